id_ex_stage_reg: RTL

//  ID/EX pipeline register of the 5-stage MIPS core; sits directly upstream of the EX-stage ALU.

---
 rtl/id_ex_stage_reg.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_reg
// Description : ID/EX pipeline register of the 5-stage MIPS core. Latches the
//               decoded operands and control of the ID stage each cycle and
//               loads a bubble on stall, flush or an empty ID slot. The ALU
//               operands are resolved combinationally from the latched values
//               plus MEM->EX and WB->EX forwarding.
// Config      : ID_EX_BUBBLE_CNT_EN - when defined, o_bubble_cnt counts the
//               bubbles loaded because of stall|flush (saturating). When not
//               defined, o_bubble_cnt is tied to 0.
// Ports       : clk, rst_n            clock, async active-low reset
//               i_stall, i_flush      bubble requests
//               i_id_*                decoded ID-stage fields
//               i_mem_*, i_wb_*       forwarding sources (write enable/addr/data)
//               o_ex_in1/in2/alu_sel  final ALU operands and op
//               o_ex_rt_fwd           forwarded rt (store data)
//               o_ex_pc/wr_addr/reg_write/valid  registered passthrough
//               o_bubble_cnt          bubble counter (configuration dependent)
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage_reg #(
    parameter logic [2:0] NOP_ALU_SEL = 3'b010,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic             i_id_valid,
    input  logic [31:0]      i_id_pc,
    input  logic [31:0]      i_id_rs_data,
    input  logic [31:0]      i_id_rt_data,
    input  logic [31:0]      i_id_ext_imm,
    input  logic [4:0]       i_id_shamt,
    input  logic [4:0]       i_id_rs_addr,
    input  logic [4:0]       i_id_rt_addr,
    input  logic [4:0]       i_id_wr_addr,
    input  logic [2:0]       i_id_alu_sel,
    input  logic             i_id_src_imm,
    input  logic             i_id_is_shift,
    input  logic             i_id_reg_write,
    input  logic             i_mem_reg_write,
    input  logic [4:0]       i_mem_wr_addr,
    input  logic [31:0]      i_mem_result,
    input  logic             i_wb_reg_write,
    input  logic [4:0]       i_wb_wr_addr,
    input  logic [31:0]      i_wb_result,
    output logic [31:0]      o_ex_in1,
    output logic [31:0]      o_ex_in2,
    output logic [2:0]       o_ex_alu_sel,
    output logic [31:0]      o_ex_rt_fwd,
    output logic [31:0]      o_ex_pc,
    output logic [4:0]       o_ex_wr_addr,
    output logic             o_ex_reg_write,
    output logic             o_ex_valid,
    output logic [CNT_W-1:0] o_bubble_cnt
);

    logic        r_valid;
    logic        r_reg_write;
    logic [4:0]  r_wr_addr;
    logic [31:0] r_pc;
    logic [4:0]  r_rs_addr;
    logic [4:0]  r_rt_addr;
    logic [31:0] r_rs_data;
    logic [31:0] r_rt_data;
    logic [31:0] r_ext_imm;
    logic [4:0]  r_shamt;
    logic [2:0]  r_alu_sel;
    logic        r_src_imm;
    logic        r_is_shift;

    logic        w_bubble;
    logic [31:0] w_fwd_rs;
    logic [31:0] w_fwd_rt;

    // An empty ID slot also becomes a bubble, but only stall|flush is counted.
    assign w_bubble = i_stall | i_flush | ~i_id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_wr_addr   <= 5'd0;
            r_pc        <= 32'd0;
            r_rs_addr   <= 5'd0;
            r_rt_addr   <= 5'd0;
            r_rs_data   <= 32'd0;
            r_rt_data   <= 32'd0;
            r_ext_imm   <= 32'd0;
            r_shamt     <= 5'd0;
            r_alu_sel   <= NOP_ALU_SEL;
            r_src_imm   <= 1'b0;
            r_is_shift  <= 1'b0;
        end else if (w_bubble) begin
            // Bubble: zero operands through an add, result discarded.
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_wr_addr   <= 5'd0;
            r_pc        <= 32'd0;
            r_rs_addr   <= 5'd0;
            r_rt_addr   <= 5'd0;
            r_rs_data   <= 32'd0;
            r_rt_data   <= 32'd0;
            r_ext_imm   <= 32'd0;
            r_shamt     <= 5'd0;
            r_alu_sel   <= NOP_ALU_SEL;
            r_src_imm   <= 1'b0;
            r_is_shift  <= 1'b0;
        end else begin
            r_valid     <= 1'b1;
            r_reg_write <= i_id_reg_write;
            r_wr_addr   <= i_id_wr_addr;
            r_pc        <= i_id_pc;
            r_rs_addr   <= i_id_rs_addr;
            r_rt_addr   <= i_id_rt_addr;
            r_rs_data   <= i_id_rs_data;
            r_rt_data   <= i_id_rt_data;
            r_ext_imm   <= i_id_ext_imm;
            r_shamt     <= i_id_shamt;
            r_alu_sel   <= i_id_alu_sel;
            r_src_imm   <= i_id_src_imm;
            r_is_shift  <= i_id_is_shift;
        end
    end

    // Forwarding: $zero is never forwarded; the younger MEM result wins over WB.
    always_comb begin
        w_fwd_rs = r_rs_data;
        if (r_rs_addr != 5'd0) begin
            if (i_mem_reg_write && (i_mem_wr_addr == r_rs_addr)) begin
                w_fwd_rs = i_mem_result;
            end else if (i_wb_reg_write && (i_wb_wr_addr == r_rs_addr)) begin
                w_fwd_rs = i_wb_result;
            end
        end
    end

    always_comb begin
        w_fwd_rt = r_rt_data;
        if (r_rt_addr != 5'd0) begin
            if (i_mem_reg_write && (i_mem_wr_addr == r_rt_addr)) begin
                w_fwd_rt = i_mem_result;
            end else if (i_wb_reg_write && (i_wb_wr_addr == r_rt_addr)) begin
                w_fwd_rt = i_wb_result;
            end
        end
    end

    // Shifts take the value from rt and the amount from the shamt field.
    assign o_ex_in1       = r_is_shift ? w_fwd_rt : w_fwd_rs;
    assign o_ex_in2       = r_is_shift ? {27'd0, r_shamt}
                          : (r_src_imm ? r_ext_imm : w_fwd_rt);
    assign o_ex_alu_sel   = r_alu_sel;
    assign o_ex_rt_fwd    = w_fwd_rt;
    assign o_ex_pc        = r_pc;
    assign o_ex_wr_addr   = r_wr_addr;
    assign o_ex_reg_write = r_reg_write;
    assign o_ex_valid     = r_valid;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CNT_W-1:0] r_bubble_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if ((i_stall | i_flush) && (r_bubble_cnt != {CNT_W{1'b1}})) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign o_bubble_cnt = r_bubble_cnt;
`else
    assign o_bubble_cnt = '0;
`endif

endmodule
`default_nettype wire
